glb_rd_streamer: RTL and testbench

- Read-side initiator for one global-buffer bank (ifmap, weight or psum).
- Takes a programmed burst descriptor (base, count, stride) and drives the bank's read_req/r_addr pins.
- Captures r_data at fixed read latency and presents it to the PE-array feeder as a valid/ready stream with last-flag.
- Instantiated once per GLB bank; sits between GB_Cluster read ports and the PE distribution network.

---
 rtl/glb_pkg.sv | 8 +
 rtl/glb_rd_streamer_if.sv | 28 ++
 rtl/glb_sync_fifo.sv | 38 +++
 rtl/glb_rd_streamer.sv | 112 +++++++++++
 tb/tb_glb_rd_streamer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/glb_pkg.sv
// glb_pkg: GLB widths and read latency shared with GB_Cluster, plus the streamer FSM states.
package glb_pkg;
    localparam int GLB_DATA_BITWIDTH = 16;
    localparam int GLB_ADDR_BITWIDTH = 10;
    localparam int GLB_CNT_BITWIDTH  = 10;
    localparam int GLB_RD_LATENCY    = 1;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} glb_state_e;
endpackage

// File: rtl/glb_rd_streamer_if.sv
// glb_rd_streamer_if: descriptor, GLB read port and output stream of one bank streamer.
interface glb_rd_streamer_if #(
    parameter int DATA_BITWIDTH = 16,
    parameter int ADDR_BITWIDTH = 10,
    parameter int CNT_BITWIDTH  = 10
);
    logic                     start;
    logic [ADDR_BITWIDTH-1:0] base_addr;
    logic [ADDR_BITWIDTH-1:0] stride;
    logic [CNT_BITWIDTH-1:0]  count;
    logic                     busy;
    logic                     done;
    logic                     read_req;
    logic [ADDR_BITWIDTH-1:0] r_addr;
    logic [DATA_BITWIDTH-1:0] r_data;
    logic                     out_valid;
    logic [DATA_BITWIDTH-1:0] out_data;
    logic                     out_last;
    logic                     out_ready;
    modport master (
        input  start, base_addr, stride, count, r_data, out_ready,
        output busy, done, read_req, r_addr, out_valid, out_data, out_last
    );
    modport slave (
        output start, base_addr, stride, count, r_data, out_ready,
        input  busy, done, read_req, r_addr, out_valid, out_data, out_last
    );
endinterface

// File: rtl/glb_sync_fifo.sv
// glb_sync_fifo: power-of-two synchronous FIFO with occupancy output, async active-low reset.
module glb_sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_occ
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr, r_rd;
    logic [AW:0]      r_occ;
    logic             w_push, w_pop;
    assign w_pop  = i_pop && r_occ != '0;
    assign w_push = i_push && (r_occ != (AW+1)'(DEPTH) || w_pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            r_occ <= r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;
    assign o_data  = r_mem[r_rd];
    assign o_empty = r_occ == '0;
    assign o_occ   = r_occ;
endmodule

// File: rtl/glb_rd_streamer.sv
// glb_rd_streamer: credit-limited GLB burst reader feeding a valid/ready stream with last-flag.
// Optional stall_cycles counter enabled by GLB_RD_STREAMER_STALL_CNT_EN.
module glb_rd_streamer
    import glb_pkg::*;
#(
    parameter int DATA_BITWIDTH = GLB_DATA_BITWIDTH,
    parameter int ADDR_BITWIDTH = GLB_ADDR_BITWIDTH,
    parameter int CNT_BITWIDTH  = GLB_CNT_BITWIDTH,
    parameter int RD_LATENCY    = GLB_RD_LATENCY,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic              clk,
    input  logic              reset,
    glb_rd_streamer_if.master bus
`ifdef GLB_RD_STREAMER_STALL_CNT_EN
    , output logic [31:0]     stall_cycles
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 2;
    glb_state_e               r_state, w_next;
    logic [ADDR_BITWIDTH-1:0] r_next_addr, r_stride, r_rd_addr, w_req_addr;
    logic [CNT_BITWIDTH-1:0]  r_count, r_issued;
    logic                     r_read_req, r_read_last, r_zero;
    logic [RD_LATENCY-1:0]    r_dly, r_dly_last;
    logic [AW:0]              w_occ;
    logic [CW-1:0]            w_sum;
    logic [DATA_BITWIDTH:0]   w_head;
    logic w_empty, w_start, w_first, w_req, w_req_last, w_pop, w_last_pop, w_busy;
    assign w_start    = bus.start && r_state == IDLE;
    assign w_first    = w_start && bus.count != '0;
    assign w_sum      = CW'(r_read_req) + CW'($countones(r_dly)) + CW'(w_occ);
    assign w_req      = w_first || (r_state == ISSUE && w_sum < CW'(FIFO_DEPTH));
    assign w_req_last = w_first ? bus.count == CNT_BITWIDTH'(1)
                                : w_req && r_issued == r_count - CNT_BITWIDTH'(1);
    assign w_req_addr = w_first ? bus.base_addr : r_next_addr;
    assign w_pop      = !w_empty && bus.out_ready;
    assign w_last_pop = w_pop && w_head[DATA_BITWIDTH];
    assign w_busy     = r_state == ISSUE || r_state == DRAIN || (r_state == DONE && r_zero);
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = bus.count == '0 ? DONE : (w_req_last ? DRAIN : ISSUE);
            ISSUE:   if (w_req_last) w_next = DRAIN;
            DRAIN:   if (!r_read_req && r_dly == '0 && w_last_pop) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_next_addr <= '0;
            r_stride    <= '0;
            r_rd_addr   <= '0;
            r_count     <= '0;
            r_issued    <= '0;
            r_read_req  <= 1'b0;
            r_read_last <= 1'b0;
            r_zero      <= 1'b0;
            r_dly       <= '0;
            r_dly_last  <= '0;
        end else begin
            r_state     <= w_next;
            r_read_req  <= w_req;
            r_read_last <= w_req && w_req_last;
            if (w_start) begin
                r_stride <= bus.stride;
                r_count  <= bus.count;
                r_zero   <= bus.count == '0;
            end
            if (w_req) begin
                r_rd_addr   <= w_req_addr;
                r_next_addr <= w_req_addr + (w_first ? bus.stride : r_stride);
                r_issued    <= w_first ? CNT_BITWIDTH'(1) : r_issued + CNT_BITWIDTH'(1);
            end
            // Tag each request so its data is captured exactly RD_LATENCY cycles later.
            r_dly[0]      <= r_read_req;
            r_dly_last[0] <= r_read_last;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_dly[i]      <= r_dly[i-1];
                r_dly_last[i] <= r_dly_last[i-1];
            end
        end
    end
    glb_sync_fifo #(.WIDTH(DATA_BITWIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (r_dly[RD_LATENCY-1]),
        .i_data  ({r_dly_last[RD_LATENCY-1], bus.r_data}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_empty (w_empty),
        .o_occ   (w_occ)
    );
    assign bus.busy      = w_busy;
    assign bus.done      = r_state == DONE;
    assign bus.read_req  = r_read_req;
    assign bus.r_addr    = r_rd_addr;
    assign bus.out_valid = !w_empty;
    // Head is masked when empty so stale entries never show on the stream pins.
    assign bus.out_data  = w_empty ? '0 : w_head[DATA_BITWIDTH-1:0];
    assign bus.out_last  = !w_empty && w_head[DATA_BITWIDTH];
`ifdef GLB_RD_STREAMER_STALL_CNT_EN
    logic [31:0] r_stall;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_stall <= '0;
        else if (w_start) r_stall <= '0;
        else if (w_busy && !w_empty && !bus.out_ready && r_stall != '1) r_stall <= r_stall + 32'd1;
    end
    assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_glb_rd_streamer.sv
// tb_glb_rd_streamer: directed vector table, reset/stall sequences and random bursts
// checked against an address/data/last model of the burst.
module tb_glb_rd_streamer;
    localparam int DW = 16, AW = 10, CW = 10, DEPTH = 4;
    logic clk = 1'b0, reset = 1'b0;
    always #5 clk = ~clk;
    glb_rd_streamer_if #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .CNT_BITWIDTH(CW)) bus();
`ifdef GLB_RD_STREAMER_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif
    glb_rd_streamer #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .CNT_BITWIDTH(CW),
                      .RD_LATENCY(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus)
`ifdef GLB_RD_STREAMER_STALL_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );
    logic [15:0] mem [1024];
    always @(posedge clk) bus.r_data <= bus.read_req ? mem[bus.r_addr] : 16'($urandom);
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    int n_checks = 0, n_err = 0;
    task automatic chk(input string nm, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask
    int q_addr[$], q_rcyc[$], q_out[$];
    int n_req, n_pop, n_done, n_busy, n_valid, max_out, last_hs_cyc, done_cyc, hold_word;
    bit hold;
    always @(negedge clk) begin
        if (!reset) hold = 1'b0;
        else begin
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1);
                chk("hold_word", {bus.out_last, bus.out_data}, hold_word);
            end
            if (bus.read_req) begin
                q_addr.push_back(bus.r_addr);
                q_rcyc.push_back(cyc);
                n_req++;
            end
            if (n_req - n_pop > max_out) max_out = n_req - n_pop;
            chk("credit", int'(n_req - n_pop <= DEPTH), 1);
            if (bus.out_valid && bus.out_ready) begin
                q_out.push_back({bus.out_last, bus.out_data});
                n_pop++;
                last_hs_cyc = cyc;
            end
            if (bus.done) begin n_done++; done_cyc = cyc; end
            if (bus.busy) n_busy++;
            if (bus.out_valid) n_valid++;
            hold = bus.out_valid && !bus.out_ready;
            hold_word = {bus.out_last, bus.out_data};
        end
    end
    int ready_mode = 0, start_cyc = 0;
    bit manual_ready = 1'b0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: bus.out_ready = $urandom_range(0, 3) != 0;
            2: bus.out_ready = !((cyc - start_cyc) inside {[3:10]});
            3: bus.out_ready = manual_ready;
            default: bus.out_ready = 1'b1;
        endcase
    end
    task automatic do_start(input int b, input int s, input int c);
        q_addr.delete(); q_rcyc.delete(); q_out.delete();
        n_req = 0; n_pop = 0; n_done = 0; n_busy = 0; n_valid = 0; max_out = 0;
        last_hs_cyc = -1; done_cyc = -1;
        @(posedge clk); #2;
        start_cyc = cyc;
        bus.base_addr = 10'(b); bus.stride = 10'(s); bus.count = 10'(c); bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
    endtask
    task automatic wait_done(input string nm);
        int t = 0;
        do begin @(negedge clk); t++; end while (!bus.done && t < 3000);
        chk({nm, "_done_seen"}, bus.done, 1);
        repeat (2) @(negedge clk);
    endtask
    task automatic chk_zero(input string nm);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_done"}, bus.done, 0);
        chk({nm, "_read_req"}, bus.read_req, 0);
        chk({nm, "_r_addr"}, bus.r_addr, 0);
        chk({nm, "_out_valid"}, bus.out_valid, 0);
        chk({nm, "_out_data"}, bus.out_data, 0);
        chk({nm, "_out_last"}, bus.out_last, 0);
    endtask
    task automatic run_burst(input int b, input int s, input int c, input int mode,
                             input int exp_last, input string nm);
        int a;
        ready_mode = mode;
        do_start(b, s, c);
        wait_done(nm);
        chk({nm, "_nreq"}, q_addr.size(), c);
        chk({nm, "_nout"}, q_out.size(), c);
        chk({nm, "_ndone"}, n_done, 1);
        for (int k = 0; k < c && k < q_addr.size(); k++)
            chk($sformatf("%s_addr%0d", nm, k), q_addr[k], (b + k * s) & 1023);
        for (int k = 0; k < c && k < q_out.size(); k++) begin
            a = (b + k * s) & 1023;
            chk($sformatf("%s_data%0d", nm, k), q_out[k] & 16'hFFFF, mem[a]);
            chk($sformatf("%s_last%0d", nm, k), q_out[k] >> 16, int'(k == c - 1));
        end
        if (c > 0) begin
            chk({nm, "_last_addr"}, q_addr.size() == c ? q_addr[c-1] : -1, exp_last);
            chk({nm, "_done_lat"}, done_cyc - last_hs_cyc, 1);
        end else begin
            chk({nm, "_busy_cycles"}, n_busy, 1);
            chk({nm, "_no_valid"}, n_valid, 0);
        end
        if (mode == 0 && c > 0 && q_rcyc.size() == c) begin
            chk({nm, "_first_req"}, q_rcyc[0] - start_cyc, 1);
            chk({nm, "_back2back"}, q_rcyc[c-1] - q_rcyc[0], c - 1);
        end
        if (mode == 2) chk({nm, "_credit_peak"}, max_out, DEPTH);
    endtask
    typedef struct { int b; int s; int c; int mode; int exp_last; string nm; } vec_t;
    vec_t vt [6];
    initial begin
        int t, b, s, c;
        vt[0] = '{'h010, 1, 5, 0, 'h014, "basic"};
        vt[1] = '{'h100, 2, 8, 2, 'h10E, "backpressure"};
        vt[2] = '{'h3FE, 3, 3, 0, 'h004, "wrap"};
        vt[3] = '{'h055, 1, 0, 0, 0, "zero"};
        vt[4] = '{'h000, 0, 1, 0, 'h000, "single"};
        vt[5] = '{'h200, 'h3FF, 4, 0, 'h1FD, "neg_stride"};
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i);
        bus.start = 1'b0; bus.base_addr = '0; bus.stride = '0; bus.count = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        @(negedge clk);
        foreach (vt[i]) run_burst(vt[i].b, vt[i].s, vt[i].c, vt[i].mode, vt[i].exp_last, vt[i].nm);
        ready_mode = 0;
        do_start('h040, 1, 10);
        t = 0;
        do begin @(negedge clk); t++; end while (n_req < 2 && t < 100);
        chk("rst_mid_two_req", n_req, 2);
        #1 reset = 1'b0;
        #1 chk_zero("rst_mid");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_no_done", n_done, 0);
        chk("rst_idle_busy", bus.busy, 0);
        run_burst('h060, 2, 2, 0, 'h062, "post_rst");
`ifdef GLB_RD_STREAMER_STALL_CNT_EN
        ready_mode = 3; manual_ready = 1'b0;
        do_start('h080, 1, 4);
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.out_valid && t < 100);
        chk("stall_valid_seen", bus.out_valid, 1);
        repeat (5) @(negedge clk);
        manual_ready = 1'b1;
        wait_done("stall");
        chk("stall_cycles", stall_cycles, 6);
        ready_mode = 0;
        do_start('h090, 1, 2);
        @(negedge clk);
        chk("stall_clear", stall_cycles, 0);
        wait_done("stall2");
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 25; i++) begin
            b = $urandom_range(0, 1023);
            s = $urandom_range(0, 1023);
            c = $urandom_range(0, 20);
            run_burst(b, s, c, 1, c > 0 ? (b + (c - 1) * s) & 1023 : 0, $sformatf("rnd%0d", i));
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
